// File: rtl/odu_chid_rr_sched_if.sv
// rtl/odu_chid_rr_sched_if.sv - control, channel status and grant signals of the channel-ID round-robin scheduler
//
// Signals (master = scheduler side):
//   start, stop        in   one-cycle control pulses
//   out_ready          in   downstream can take a word
//   enable_chid        in   per-channel enable
//   i_error_chid       in   per-channel error mask (set = skip)
//   fifo_empty         in   per-channel FIFO empty flag
//   fifo_read_enable   out  registered one-hot FIFO read strobe
//   chid_out           out  channel of the word on the FIFO data bus
//   chid_valid         out  chid_out / FIFO data valid
//   busy               out  scheduler in RUN
//   word_cnt           out  grants since last start
interface odu_chid_rr_sched_if #(
    parameter int NUM_CH = 80,
    parameter int CHID_W = 7
);
    logic              start;
    logic              stop;
    logic              out_ready;
    logic [NUM_CH-1:0] enable_chid;
    logic [NUM_CH-1:0] i_error_chid;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] fifo_read_enable;
    logic [CHID_W-1:0] chid_out;
    logic              chid_valid;
    logic              busy;
    logic [31:0]       word_cnt;

    modport master (
        input  start, stop, out_ready, enable_chid, i_error_chid, fifo_empty,
        output fifo_read_enable, chid_out, chid_valid, busy, word_cnt
    );

    modport slave (
        output start, stop, out_ready, enable_chid, i_error_chid, fifo_empty,
        input  fifo_read_enable, chid_out, chid_valid, busy, word_cnt
    );
endinterface

// File: rtl/odu_chid_rr_sched.sv
// rtl/odu_chid_rr_sched.sv - round-robin read scheduler over NUM_CH channel FIFOs
//
// Ports:
//   clk   single rising-edge clock
//   rst   synchronous active-low reset
//   bus   odu_chid_rr_sched_if.master (control inputs, channel status,
//         FIFO read strobe, channel-ID/valid, busy, word counter)
module odu_chid_rr_sched #(
    parameter int NUM_CH = 80,
    parameter int CHID_W = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    odu_chid_rr_sched_if.master    bus
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [NUM_CH-1:0] rd_en_q;
    logic [CHID_W-1:0] last_grant_q;
    logic [CHID_W-1:0] chid_q;
    logic              chid_valid_q;
    logic [31:0]       word_cnt_q;

    logic              grant_ok;
    logic [NUM_CH-1:0] eligible;
    logic              grant_vld;
    logic [CHID_W-1:0] grant_idx;
    logic [CHID_W:0]   probe;
    logic [NUM_CH-1:0] grant_onehot;

    always_comb begin
        state_d = state_q;
        if (bus.stop) begin
            state_d = IDLE;
        end else if (bus.start) begin
            state_d = RUN;
        end
    end

    // The stop cycle itself issues no grant: only the strobe already
    // registered is allowed to drain after stop.
    assign grant_ok = (state_q == RUN) && bus.out_ready && !bus.stop;

    // Excluding the channel currently strobed is the guard cycle that keeps
    // a lone channel from being read back-to-back.
    assign eligible = {NUM_CH{grant_ok}} & bus.enable_chid & ~bus.i_error_chid
                    & ~bus.fifo_empty & ~rd_en_q;

    // Search from last_grant+1 around to last_grant itself; the first hit wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_grant_q;
        probe     = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            probe = {1'b0, last_grant_q} + (CHID_W+1)'(k);
            if (probe >= (CHID_W+1)'(NUM_CH)) begin
                probe = probe - (CHID_W+1)'(NUM_CH);
            end
            if (!grant_vld && eligible[probe[CHID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = probe[CHID_W-1:0];
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        if (grant_vld) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            rd_en_q      <= '0;
            last_grant_q <= CHID_W'(NUM_CH - 1);
            chid_q       <= '0;
            chid_valid_q <= 1'b0;
            word_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_en_q <= grant_onehot;
            if (grant_vld) begin
                last_grant_q <= grant_idx;
            end
            // While a strobe is up, last_grant_q holds its index, so the
            // channel ID lines up with the FIFO data one cycle later.
            chid_valid_q <= |rd_en_q;
            if (|rd_en_q) begin
                chid_q <= last_grant_q;
            end
            if (state_q == IDLE && state_d == RUN) begin
                word_cnt_q <= '0;
            end else if (grant_vld) begin
                word_cnt_q <= word_cnt_q + 32'd1;
            end
        end
    end

    assign bus.fifo_read_enable = rd_en_q;
    assign bus.chid_out         = chid_q;
    assign bus.chid_valid       = chid_valid_q;
    assign bus.busy             = (state_q == RUN);
    assign bus.word_cnt         = word_cnt_q;

endmodule

// File: tb/tb_odu_chid_rr_sched.sv
// tb/tb_odu_chid_rr_sched.sv - randomized and directed bench for odu_chid_rr_sched against a behavioural model
module tb_odu_chid_rr_sched;

    localparam int NUM_CH = 80;
    localparam int CHID_W = 7;

    typedef logic [NUM_CH-1:0] chv_t;

    logic clk;
    logic rst;

    odu_chid_rr_sched_if #(.NUM_CH(NUM_CH), .CHID_W(CHID_W)) bus ();

    odu_chid_rr_sched #(.NUM_CH(NUM_CH), .CHID_W(CHID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model state: what the outputs must look like after the next edge.
    bit          m_run;
    int          m_last;
    int          m_strobe;
    bit          m_valid;
    int          m_chid;
    logic [31:0] m_cnt;
    bit          chk_on;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic chv_t rnd_ch();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[NUM_CH-1:0];
    endfunction

    task automatic model_step(input logic rs, input logic st, input logic sp, input logic rdy,
                              input chv_t en, input chv_t er, input chv_t em);
        int g;
        int i;
        if (!rs) begin
            m_run    = 1'b0;
            m_last   = NUM_CH - 1;
            m_strobe = -1;
            m_valid  = 1'b0;
            m_chid   = 0;
            m_cnt    = '0;
        end else begin
            g = -1;
            if (m_run && rdy && !sp) begin
                for (int k = 1; k <= NUM_CH; k++) begin
                    i = (m_last + k) % NUM_CH;
                    if (g < 0 && en[i] && !er[i] && !em[i] && i != m_strobe) g = i;
                end
            end
            m_valid = (m_strobe >= 0);
            if (m_valid) m_chid = m_strobe;
            if (!m_run && st && !sp) m_cnt = '0;
            else if (g >= 0) m_cnt = m_cnt + 32'd1;
            if (sp) m_run = 1'b0;
            else if (st) m_run = 1'b1;
            if (g >= 0) m_last = g;
            m_strobe = g;
        end
    endtask

    task automatic tick(input logic rs, input logic st, input logic sp, input logic rdy,
                        input chv_t en, input chv_t er, input chv_t em);
        chv_t exp_rd;
        @(negedge clk);
        if (chk_on) begin
            exp_rd = '0;
            if (m_strobe >= 0) exp_rd[m_strobe] = 1'b1;
            check_eq("fifo_read_enable", 128'(bus.fifo_read_enable), 128'(exp_rd));
            check_eq("chid_valid", 128'(bus.chid_valid), 128'(m_valid));
            check_eq("chid_out", 128'(bus.chid_out), 128'(m_chid));
            check_eq("busy", 128'(bus.busy), 128'(m_run));
            check_eq("word_cnt", 128'(bus.word_cnt), 128'(m_cnt));
        end
        rst              = rs;
        bus.start        = st;
        bus.stop         = sp;
        bus.out_ready    = rdy;
        bus.enable_chid  = en;
        bus.i_error_chid = er;
        bus.fifo_empty   = em;
        model_step(rs, st, sp, rdy, en, er, em);
        chk_on = 1'b1;
    endtask

    initial begin
        chv_t all1;
        chv_t all0;
        chv_t em;
        chv_t er;
        chv_t en;
        logic rs;
        logic st;
        logic sp;
        logic rdy;

        n_vec  = 0;
        n_err  = 0;
        chk_on = 1'b0;
        all1   = '1;
        all0   = '0;
        rst              = 1'b0;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.out_ready    = 1'b0;
        bus.enable_chid  = '0;
        bus.i_error_chid = '0;
        bus.fifo_empty   = '1;

        // Reset state
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, all0, all0, all1);
        tick(1'b1, 1'b0, 1'b0, 1'b1, all1, all0, all0);

        // All channels ready: 0..79 then wrap to 0
        tick(1'b1, 1'b1, 1'b0, 1'b1, all1, all0, all0);
        repeat (84) tick(1'b1, 1'b0, 1'b0, 1'b1, all1, all0, all0);
        tick(1'b1, 1'b0, 1'b1, 1'b1, all1, all0, all0);
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b1, all1, all0, all0);

        // Only 5 and 78 non-empty: wrap 78 -> 5
        em = all1; em[5] = 1'b0; em[78] = 1'b0;
        tick(1'b1, 1'b1, 1'b0, 1'b1, all1, all0, em);
        repeat (8) tick(1'b1, 1'b0, 1'b0, 1'b1, all1, all0, em);
        tick(1'b1, 1'b0, 1'b1, 1'b1, all1, all0, em);
        repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b1, all1, all0, em);

        // Only channel 10: every other cycle
        em = all1; em[10] = 1'b0;
        tick(1'b1, 1'b1, 1'b0, 1'b1, all1, all0, em);
        repeat (10) tick(1'b1, 1'b0, 1'b0, 1'b1, all1, all0, em);
        tick(1'b1, 1'b0, 1'b1, 1'b1, all1, all0, em);
        repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b1, all1, all0, em);

        // Error on 3, disable 4, channels 0..7 non-empty
        em = all1; em[7:0] = 8'h00;
        er = all0; er[3] = 1'b1;
        en = all1; en[4] = 1'b0;
        tick(1'b1, 1'b1, 1'b0, 1'b1, en, er, em);
        repeat (14) tick(1'b1, 1'b0, 1'b0, 1'b1, en, er, em);

        // out_ready low for 4 cycles mid-RUN
        repeat (5) tick(1'b1, 1'b0, 1'b0, 1'b1, all1, all0, all0);
        repeat (4) tick(1'b1, 1'b0, 1'b0, 1'b0, all1, all0, all0);
        repeat (5) tick(1'b1, 1'b0, 1'b0, 1'b1, all1, all0, all0);

        // start and stop together in RUN, restart, then reset mid-RUN
        tick(1'b1, 1'b1, 1'b1, 1'b1, all1, all0, all0);
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b1, all1, all0, all0);
        tick(1'b1, 1'b1, 1'b1, 1'b1, all1, all0, all0);
        tick(1'b1, 1'b1, 1'b0, 1'b1, all1, all0, all0);
        repeat (6) tick(1'b1, 1'b0, 1'b0, 1'b1, all1, all0, all0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, all1, all0, all0);
        repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b1, all1, all0, all0);

        // Randomized traffic
        for (int blk = 0; blk < 30; blk++) begin
            for (int c = 0; c < 100; c++) begin
                rs  = ($urandom_range(0, 299) != 0);
                st  = ($urandom_range(0, 19) == 0);
                sp  = ($urandom_range(0, 49) == 0);
                rdy = ($urandom_range(0, 3) != 0);
                en  = rnd_ch() | rnd_ch();
                er  = rnd_ch() & rnd_ch() & rnd_ch();
                case (blk % 3)
                    0:       em = rnd_ch();
                    1:       em = rnd_ch() | rnd_ch() | rnd_ch() | rnd_ch();
                    default: em = ~(rnd_ch() & rnd_ch() & rnd_ch() & rnd_ch() & rnd_ch());
                endcase
                tick(rs, st, sp, rdy, en, er, em);
            end
        end

        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b1, all1, all0, all0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/odu_chid_rr_sched.md
ODU_CHID_RR_SCHED -- requirements
Module: odu_chid_rr_sched

Interface
REQ-001 Parameter NUM_CH, default 80, number of channel FIFOs served.
REQ-002 Parameter CHID_W, default 7, width of channel index; SHALL satisfy 2^CHID_W >= NUM_CH.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle pulse from the control block; begins scheduling.
REQ-006 stop  input  1  one-cycle pulse; ends scheduling.
REQ-007 out_ready  input  1  downstream accepts a word; low = no new grants.
REQ-008 enable_chid  input  NUM_CH  per-channel enable from the control block.
REQ-009 i_error_chid  input  NUM_CH  per-channel error mask; set = channel skipped.
REQ-010 fifo_empty  input  NUM_CH  per-channel FIFO empty flag.
REQ-011 fifo_read_enable  output  NUM_CH  one-hot read strobe to the channel FIFOs.
REQ-012 chid_out  output  CHID_W  index of the channel whose word is on the FIFO data bus.
REQ-013 chid_valid  output  1  chid_out and FIFO data valid this cycle.
REQ-014 busy  output  1  high while in RUN.
REQ-015 word_cnt  output  32  words granted since last start, wraps at 2^32.

Function
REQ-016 States SHALL be IDLE and RUN; IDLE->RUN on start; RUN->IDLE on stop; start in RUN and stop in IDLE ignored.
REQ-017 start and stop in the same cycle: stop wins (state IDLE next cycle).
REQ-018 Channel i eligible in cycle N when state RUN, out_ready=1, enable_chid[i]=1, i_error_chid[i]=0, fifo_empty[i]=0, and i not granted in cycle N-1.
REQ-019 Grant SHALL be round-robin: search begins at last_grant+1, wraps from NUM_CH-1 to 0, first eligible index wins.
REQ-020 fifo_read_enable SHALL be registered: eligibility evaluated in cycle N, one-hot strobe high in cycle N+1 for exactly one cycle.
REQ-021 At most one bit of fifo_read_enable SHALL be high in any cycle; all zero when no channel eligible.
REQ-022 last_grant SHALL update only on a grant; no grant leaves it unchanged.
REQ-023 chid_out SHALL equal the index strobed in cycle N+1 and chid_valid SHALL be high in cycle N+2 (one cycle after the strobe, aligned with FIFO read data).
REQ-024 chid_out SHALL hold its last value while chid_valid=0.
REQ-025 A single eligible channel SHALL be granted at most every other cycle (guard cycle of REQ-018).
REQ-026 word_cnt SHALL clear to 0 on the IDLE->RUN transition and increment by 1 per fifo_read_enable strobe.
REQ-027 On stop, no new grant after the stop cycle; a strobe already registered and its chid_valid SHALL complete.
REQ-028 Changes to enable_chid or i_error_chid SHALL take effect on the next eligibility evaluation; no grant in flight is cancelled.

Reset
REQ-029 With rst=0 at a rising edge: state IDLE, fifo_read_enable=0, chid_out=0, chid_valid=0, busy=0, word_cnt=0, last_grant=NUM_CH-1 (first search starts at channel 0).
REQ-030 Reset mid-RUN SHALL abort immediately; pending strobe and chid_valid SHALL be dropped.

Verification
REQ-031 Reset, start, all channels enabled and non-empty, out_ready=1 -> strobes on channels 0,1,2,...,79,0 in consecutive cycles; chid_valid one cycle after each strobe with matching chid_out.
REQ-032 Only channels 5 and 78 non-empty -> grant order 5,78,5,78; channel 78 -> 5 wraps correctly.
REQ-033 Only channel 10 non-empty, out_ready=1 -> strobes on channel 10 every other cycle, word_cnt increments by 1 each strobe.
REQ-034 i_error_chid[3]=1, enable_chid[4]=0, channels 0..7 non-empty -> order 0,1,2,5,6,7; 3 and 4 never strobed.
REQ-035 out_ready low 4 cycles mid-RUN -> no strobes during those cycles; on return, grant resumes at last_grant+1.
REQ-036 start and stop same cycle during RUN -> busy=0 next cycle, no further strobes after the in-flight one; next start clears word_cnt to 0; rst=0 mid-RUN -> all outputs at reset values next cycle.
